reg_write_ctrl: RTL

//  Write-side initiator for the 32x32 register file: merges ALU results and memory-load

---
 rtl/reg_write_ctrl_if.sv | 29 ++
 rtl/reg_write_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_ctrl_if.sv
// reg_write_ctrl_if: ALU-result and memory-load handshake bundle for reg_write_ctrl.
//   alu_valid/alu_ready/alu_dest/alu_data      ALU result channel
//   mem_valid/mem_ready/mem_dest/mem_data      load result channel
//   mem_op/mem_addr_lo                         load type and byte offset
// master: producer side (drives valid/payload). slave: reg_write_ctrl side (drives readies).
interface reg_write_ctrl_if;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_dest;
    logic [31:0] mem_data;
    logic [2:0]  mem_op;
    logic [1:0]  mem_addr_lo;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output mem_valid, mem_dest, mem_data, mem_op, mem_addr_lo,
        input  alu_ready, mem_ready
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  mem_valid, mem_dest, mem_data, mem_op, mem_addr_lo,
        output alu_ready, mem_ready
    );
endinterface

// File: rtl/reg_write_ctrl.sv
// reg_write_ctrl: write-side initiator for the 32x32 register file. Each cycle issues at most
// one write, chosen from an ALU result or the head of a small load-result FIFO. Loads are
// sign/zero extended or merged (LB/LBU/LH/LHU/LW/LWL/LWR) and mapped to byte-lane enables.
// Ports:
//   CLOCK, RESET        clock (posedge) and synchronous active-high reset
//   bus                 ALU/load handshake bundle (slave modport)
//   dest_addr           registered write address
//   write_datas_in      registered write data
//   writeReg_L          registered write enable, active-low
//   write*_L            registered byte-lane enables, active-low (HighEx = [31:24] .. LowAx = [7:0])
//   busy_mask           bit r set while a queued load targets r (bit 0 never set)
module reg_write_ctrl #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic             CLOCK,
    input  logic             RESET,
    reg_write_ctrl_if.slave  bus,
    output logic [4:0]       dest_addr,
    output logic [31:0]      write_datas_in,
    output logic             writeReg_L,
    output logic             writeHighEx_L,
    output logic             writeHighAx_L,
    output logic             writeLowEx_L,
    output logic             writeLowAx_L,
    output logic [31:0]      busy_mask
);
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned WaitW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLbu = 3'b001;
    localparam logic [2:0] OpLh  = 3'b010;
    localparam logic [2:0] OpLhu = 3'b011;
    localparam logic [2:0] OpLw  = 3'b100;
    localparam logic [2:0] OpLwl = 3'b101;
    localparam logic [2:0] OpLwr = 3'b110;
    localparam logic [2:0] OpNop = 3'b111;

    // Load FIFO storage
    logic [4:0]            fifo_dest_q [FIFO_DEPTH];
    logic [2:0]            fifo_op_q   [FIFO_DEPTH];
    logic [1:0]            fifo_lo_q   [FIFO_DEPTH];
    logic [31:0]           fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_vld_q;
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic [WaitW-1:0]      wait_q, wait_d;

    // Registered write-port outputs; lane_l_q is {HighEx, HighAx, LowEx, LowAx}
    logic [4:0]  dest_q, dest_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_l_q, we_l_d;
    logic [3:0]  lane_l_q, lane_l_d;

    logic fifo_empty, fifo_full, force_mem, push, pop, alu_sel;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
    assign force_mem  = (wait_q >= WaitW'(STARVE_LIMIT)) && !fifo_empty;
    assign alu_sel    = bus.alu_valid && !force_mem;
    assign pop        = !fifo_empty && (force_mem || !bus.alu_valid);
    assign push       = bus.mem_valid && !fifo_full;

    assign bus.alu_ready = !force_mem;
    assign bus.mem_ready = !fifo_full;

    // Head entry, only ever taken from registers so a load needs one cycle in the queue
    logic [4:0]  h_dest;
    logic [2:0]  h_op;
    logic [1:0]  h_lo;
    logic [31:0] h_data;

    assign h_dest = fifo_dest_q[rd_ptr_q];
    assign h_op   = fifo_op_q[rd_ptr_q];
    assign h_lo   = fifo_lo_q[rd_ptr_q];
    assign h_data = fifo_data_q[rd_ptr_q];

    // Load formatting; ld_en is active-high {HighEx, HighAx, LowEx, LowAx}
    logic [31:0] ld_shr, ld_data;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [3:0]  ld_en;

    always_comb begin
        ld_shr  = h_data >> {h_lo, 3'b000};
        ld_byte = ld_shr[7:0];
        ld_half = h_lo[1] ? h_data[31:16] : h_data[15:0];
        ld_data = '0;
        ld_en   = 4'b1111;
        case (h_op)
            OpLb:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            OpLbu:   ld_data = {24'h0, ld_byte};
            OpLh:    ld_data = {{16{ld_half[15]}}, ld_half};
            OpLhu:   ld_data = {16'h0, ld_half};
            OpLw:    ld_data = h_data;
            // 8*(3-b) equals {~b, 3'b000} for a 2-bit b
            OpLwl: begin
                ld_data = h_data << {~h_lo, 3'b000};
                ld_en   = 4'b1111 << ~h_lo;
            end
            OpLwr: begin
                ld_data = ld_shr;
                ld_en   = 4'b1111 >> h_lo;
            end
            default: ld_en = 4'b0000;
        endcase
    end

    // Write-port next state; idle holds address/data and deasserts all enables
    always_comb begin
        dest_d   = dest_q;
        wdata_d  = wdata_q;
        we_l_d   = 1'b1;
        lane_l_d = 4'b1111;
        if (alu_sel) begin
            dest_d  = bus.alu_dest;
            wdata_d = bus.alu_data;
            if (bus.alu_dest != 5'd0) begin
                we_l_d   = 1'b0;
                lane_l_d = 4'b0000;
            end
        end else if (pop && (h_op != OpNop)) begin
            dest_d  = h_dest;
            wdata_d = ld_data;
            if (h_dest != 5'd0) begin
                we_l_d   = 1'b0;
                lane_l_d = ~ld_en;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: counts cycles a present head is passed over, saturating
    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop) begin
            wait_d = '0;
        end else if (wait_q < WaitW'(STARVE_LIMIT)) begin
            wait_d = wait_q + WaitW'(1);
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_q     <= '0;
            fifo_vld_q <= '0;
            dest_q     <= '0;
            wdata_q    <= '0;
            we_l_q     <= 1'b1;
            lane_l_q   <= 4'b1111;
        end else begin
            if (pop) begin
                fifo_vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q             <= rd_ptr_q + PtrW'(1);
            end
            if (push) begin
                fifo_dest_q[wr_ptr_q] <= bus.mem_dest;
                fifo_op_q[wr_ptr_q]   <= bus.mem_op;
                fifo_lo_q[wr_ptr_q]   <= bus.mem_addr_lo;
                fifo_data_q[wr_ptr_q] <= bus.mem_data;
                fifo_vld_q[wr_ptr_q]  <= 1'b1;
                wr_ptr_q              <= wr_ptr_q + PtrW'(1);
            end
            count_q  <= count_d;
            wait_q   <= wait_d;
            dest_q   <= dest_d;
            wdata_q  <= wdata_d;
            we_l_q   <= we_l_d;
            lane_l_q <= lane_l_d;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            if (fifo_vld_q[i] && (fifo_dest_q[i] != 5'd0)) begin
                busy_mask[fifo_dest_q[i]] = 1'b1;
            end
        end
    end

    assign dest_addr      = dest_q;
    assign write_datas_in = wdata_q;
    assign writeReg_L     = we_l_q;
    assign writeHighEx_L  = lane_l_q[3];
    assign writeHighAx_L  = lane_l_q[2];
    assign writeLowEx_L   = lane_l_q[1];
    assign writeLowAx_L   = lane_l_q[0];
endmodule
